// File: rtl/handshake_interconnect.sv
// ---------------------------------------------------------------------------
// handshake_interconnect
//
// Single-master, multi-slave memory-mapped interconnect. A master request is
// decoded against programmable address regions and forwarded to exactly one
// slave, which may take any number of cycles to acknowledge. A per-transaction
// timeout turns a silent slave into an error response; an address that hits
// no region is answered with an error without touching any slave.
//
// Handshake: the master presents req_m with we_m/addr_m/wd_m and holds them
// until it samples ready_m high on a rising edge; that edge accepts the
// request. req_s[sel] then stays high until the edge on which ack_s[sel] is
// sampled high (or the timeout expires). Exactly one cycle later-state,
// rvalid_m pulses for one cycle with rd_m/err_m valid; ready_m is low during
// that pulse, so the next request can be accepted on the following edge.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_m, we_m         master request valid / write enable
//   addr_m, wd_m        master byte address / write data
//   ready_m             interconnect idle and able to accept a request
//   rvalid_m            one-cycle completion pulse
//   rd_m, err_m         read data / error flag, non-zero only with rvalid_m
//   region_base/end     per-region inclusive base / exclusive end (packed)
//   req_s, we_s         per-slave request / write enable
//   addr_s, wd_s        per-slave address / write data (packed)
//   ack_s, rd_s         per-slave acknowledge / read data (packed)
//   dbg_state           current FSM state (0 idle, 1 wait, 2 resp)
// ---------------------------------------------------------------------------
module handshake_interconnect #(
    parameter int WIDTH    = 32,
    parameter int REGIONS  = 5,
    parameter int TIMEOUT  = 16,
    parameter int REL_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_m,
    input  logic                     we_m,
    input  logic [WIDTH-1:0]         addr_m,
    input  logic [WIDTH-1:0]         wd_m,
    output logic                     ready_m,
    output logic                     rvalid_m,
    output logic [WIDTH-1:0]         rd_m,
    output logic                     err_m,
    input  logic [REGIONS*WIDTH-1:0] region_base,
    input  logic [REGIONS*WIDTH-1:0] region_end,
    output logic [REGIONS-1:0]       req_s,
    output logic [REGIONS-1:0]       we_s,
    output logic [REGIONS*WIDTH-1:0] addr_s,
    output logic [REGIONS*WIDTH-1:0] wd_s,
    input  logic [REGIONS-1:0]       ack_s,
    input  logic [REGIONS*WIDTH-1:0] rd_s,
    output logic [1:0]               dbg_state
);

    localparam int SW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [SW-1:0]    sel_r;
    logic             we_r;
    logic [WIDTH-1:0] addr_r;
    logic [WIDTH-1:0] wd_r;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rd_r, rd_n;
    logic             err_r, err_n;
    logic             accept;

    // ------------------------------------------------------------------
    // Address decode. Scanning from the highest index down lets the lowest
    // matching region overwrite the others. A region with base >= end can
    // never satisfy base <= addr < end, so it is disabled implicitly.
    // ------------------------------------------------------------------
    logic             hit;
    logic [SW-1:0]    hit_idx;
    logic [WIDTH-1:0] hit_base;
    logic [WIDTH-1:0] addr_lat;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (addr_m >= region_base[i*WIDTH +: WIDTH] &&
                addr_m <  region_end[i*WIDTH +: WIDTH]) begin
                hit      = 1'b1;
                hit_idx  = SW'(i);
                hit_base = region_base[i*WIDTH +: WIDTH];
            end
        end
    end

    assign addr_lat = (REL_ADDR != 0) ? (addr_m - hit_base) : addr_m;

    // Only the selected slave's acknowledge and read data are ever looked at.
    logic             ack_sel;
    logic [WIDTH-1:0] rd_sel;

    assign ack_sel = ack_s[sel_r];
    assign rd_sel  = rd_s[int'(sel_r)*WIDTH +: WIDTH];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = rd_r;
        err_n   = err_r;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_m) begin
                    accept = 1'b1;
                    if (hit) begin
                        state_n = S_WAIT;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_RESP;
                        rd_n    = '0;
                        err_n   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Acknowledge has priority over an expiring timeout.
                if (ack_sel) begin
                    state_n = S_RESP;
                    rd_n    = we_r ? '0 : rd_sel;
                    err_n   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_RESP;
                    rd_n    = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_r  <= '0;
            we_r   <= 1'b0;
            addr_r <= '0;
            wd_r   <= '0;
            cnt    <= '0;
            rd_r   <= '0;
            err_r  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rd_r  <= rd_n;
            err_r <= err_n;
            if (accept) begin
                sel_r  <= hit_idx;
                we_r   <= we_m;
                addr_r <= addr_lat;
                wd_r   <= wd_m;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded purely from state so reset clears them at once.
    // ------------------------------------------------------------------
    always_comb begin
        req_s  = '0;
        we_s   = '0;
        addr_s = '0;
        wd_s   = '0;
        if (state == S_WAIT) begin
            req_s[sel_r]                      = 1'b1;
            we_s[sel_r]                       = we_r;
            addr_s[int'(sel_r)*WIDTH +: WIDTH] = addr_r;
            wd_s[int'(sel_r)*WIDTH +: WIDTH]   = wd_r;
        end
    end

    assign ready_m   = (state == S_IDLE) && !rst;
    assign rvalid_m  = (state == S_RESP);
    assign rd_m      = rvalid_m ? rd_r : '0;
    assign err_m     = rvalid_m & err_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_handshake_interconnect.sv
// ---------------------------------------------------------------------------
// Bench for handshake_interconnect. Two instances share all inputs: u_a with
// absolute slave addresses and u_r with region-relative slave addresses.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_handshake_interconnect;

    localparam int W  = 32;
    localparam int R  = 5;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_m = 1'b0;
    logic           we_m = 1'b0;
    logic [W-1:0]   addr_m = '0;
    logic [W-1:0]   wd_m = '0;
    logic [R*W-1:0] region_base = '0;
    logic [R*W-1:0] region_end = '0;
    logic [R-1:0]   ack_s = '0;
    logic [R*W-1:0] rd_s = '0;

    logic           ready_a, rvalid_a, err_a;
    logic [W-1:0]   rd_a;
    logic [R-1:0]   req_s_a, we_s_a;
    logic [R*W-1:0] addr_s_a, wd_s_a;
    logic [1:0]     st_a;

    logic           ready_r, rvalid_r, err_r;
    logic [W-1:0]   rd_r;
    logic [R-1:0]   req_s_r, we_s_r;
    logic [R*W-1:0] addr_s_r, wd_s_r;
    logic [1:0]     st_r;

    handshake_interconnect #(.WIDTH(W), .REGIONS(R), .TIMEOUT(TO), .REL_ADDR(0)) u_a (
        .clk(clk), .rst(rst), .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m),
        .ready_m(ready_a), .rvalid_m(rvalid_a), .rd_m(rd_a), .err_m(err_a),
        .region_base(region_base), .region_end(region_end),
        .req_s(req_s_a), .we_s(we_s_a), .addr_s(addr_s_a), .wd_s(wd_s_a),
        .ack_s(ack_s), .rd_s(rd_s), .dbg_state(st_a)
    );

    handshake_interconnect #(.WIDTH(W), .REGIONS(R), .TIMEOUT(TO), .REL_ADDR(1)) u_r (
        .clk(clk), .rst(rst), .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m),
        .ready_m(ready_r), .rvalid_m(rvalid_r), .rd_m(rd_r), .err_m(err_r),
        .region_base(region_base), .region_end(region_end),
        .req_s(req_s_r), .we_s(we_s_r), .addr_s(addr_s_r), .wd_s(wd_s_r),
        .ack_s(ack_s), .rd_s(rd_s), .dbg_state(st_r)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sl(input logic [R*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic set_region(input int i, input logic [W-1:0] b, input logic [W-1:0] e);
        region_base[i*W +: W] = b;
        region_end[i*W +: W]  = e;
    endtask

    // Driver: one complete transaction starting at a falling edge with the
    // DUT idle. exp_req == 0 means an unmapped address.
    task automatic xfer(input string tag, input logic we, input logic [W-1:0] addr,
                        input logic [W-1:0] wd, input logic [R-1:0] exp_req,
                        input int ack_wait, input logic [W-1:0] rdata,
                        input logic [W-1:0] exp_rd, input logic exp_err,
                        input logic [W-1:0] exp_addr_a, input logic [W-1:0] exp_addr_r);
        int idx;
        idx = 0;
        for (int i = 0; i < R; i++) if (exp_req[i]) idx = i;
        req_m  = 1'b1;
        we_m   = we;
        addr_m = addr;
        wd_m   = wd;
        @(negedge clk);
        req_m = 1'b0;
        chk({tag, ".req_s"}, W'(req_s_a), W'(exp_req));
        if (exp_req == '0) begin
            chk({tag, ".rvalid"}, W'(rvalid_a), 1);
            chk({tag, ".err"}, W'(err_a), W'(exp_err));
            chk({tag, ".rd"}, rd_a, exp_rd);
        end else begin
            chk({tag, ".rvalid_early"}, W'(rvalid_a), 0);
            chk({tag, ".addr_a"}, sl(addr_s_a, idx), exp_addr_a);
            chk({tag, ".addr_r"}, sl(addr_s_r, idx), exp_addr_r);
            repeat (ack_wait) @(negedge clk);
            ack_s = exp_req;
            rd_s  = {R{rdata}};
            @(negedge clk);
            ack_s = '0;
            chk({tag, ".rvalid"}, W'(rvalid_a), 1);
            chk({tag, ".err"}, W'(err_a), W'(exp_err));
            chk({tag, ".rd"}, rd_a, exp_rd);
        end
        @(negedge clk);
        chk({tag, ".rvalid_end"}, W'(rvalid_a), 0);
        chk({tag, ".ready_end"}, W'(ready_a), 1);
    endtask

    int  hi;
    bit  seen;

    initial begin
        set_region(0, 32'h000, 32'h100);
        set_region(1, 32'h100, 32'h200);
        set_region(2, 32'h200, 32'h280);
        set_region(3, 32'h400, 32'h400);   // base == end: disabled
        set_region(4, 32'h500, 32'h480);   // base > end: disabled

        // reset values
        repeat (2) @(negedge clk);
        chk("rst.ready", W'(ready_a), 0);
        chk("rst.rvalid", W'(rvalid_a), 0);
        chk("rst.rd", rd_a, 0);
        chk("rst.err", W'(err_a), 0);
        chk("rst.req_s", W'(req_s_a), 0);
        chk("rst.addr_s", addr_s_a[W-1:0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel.ready", W'(ready_a), 1);
        chk("rel.state", W'(st_a), 0);

        // read 0x104, slave 1 acks on the first wait cycle
        xfer("rd104", 1'b0, 32'h104, 32'h0, 5'b00010, 0, 32'hDEADBEEF,
             32'hDEADBEEF, 1'b0, 32'h104, 32'h004);

        // write 0x1A0 <- 0x55, three wait cycles without ack
        req_m = 1'b1; we_m = 1'b1; addr_m = 32'h1A0; wd_m = 32'h55;
        @(negedge clk);
        req_m = 1'b0;
        rd_s = {R{32'h12345678}};
        chk("wr.req_s", W'(req_s_a), 5'b00010);
        chk("wr.we_s_a", W'(we_s_a), 5'b00010);
        chk("wr.we_s_r", W'(we_s_r), 5'b00010);
        chk("wr.addr_a", sl(addr_s_a, 1), 32'h1A0);
        chk("wr.addr_r", sl(addr_s_r, 1), 32'h0A0);
        chk("wr.wd_a", sl(wd_s_a, 1), 32'h55);
        chk("wr.wd_r", sl(wd_s_r, 1), 32'h55);
        chk("wr.state_r", W'(st_r), 1);
        repeat (2) @(negedge clk);
        chk("wr.hold", W'(req_s_r), 5'b00010);
        chk("wr.no_rvalid", W'(rvalid_r), 0);
        @(negedge clk);
        ack_s = 5'b00010;
        @(negedge clk);
        ack_s = '0;
        chk("wr.rvalid", W'(rvalid_r), 1);
        chk("wr.rd", rd_r, 0);
        chk("wr.err", W'(err_r), 0);
        chk("wr.ready_resp", W'(ready_r), 0);
        @(negedge clk);
        chk("wr.ready_end", W'(ready_r), 1);

        // unmapped accesses and region boundaries
        xfer("rd300", 1'b0, 32'h300, 32'h0, 5'b00000, 0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        xfer("rd0ff", 1'b0, 32'h0FF, 32'h0, 5'b00001, 1, 32'hCAFE0001,
             32'hCAFE0001, 1'b0, 32'h0FF, 32'h0FF);
        xfer("rd200", 1'b0, 32'h200, 32'h0, 5'b00100, 0, 32'hCAFE0002,
             32'hCAFE0002, 1'b0, 32'h200, 32'h000);
        xfer("rd27f", 1'b0, 32'h27F, 32'h0, 5'b00100, 2, 32'hCAFE0003,
             32'hCAFE0003, 1'b0, 32'h27F, 32'h07F);
        xfer("rd280", 1'b0, 32'h280, 32'h0, 5'b00000, 0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        xfer("rd4a0", 1'b0, 32'h4A0, 32'h0, 5'b00000, 0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);

        // timeout on slave 0 with a spurious ack on port 2
        req_m = 1'b1; we_m = 1'b0; addr_m = 32'h010;
        @(negedge clk);
        req_m = 1'b0;
        ack_s = 5'b00100;
        rd_s  = {R{32'hAAAA5555}};
        hi = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rvalid_a) begin
                seen = 1'b1;
                break;
            end
            if (req_s_a == 5'b00001) hi++;
            @(negedge clk);
        end
        ack_s = '0;
        chk("to.seen", W'(seen), 1);
        chk("to.req_cycles", W'(hi), TO);
        chk("to.err", W'(err_a), 1);
        chk("to.rd", rd_a, 0);
        @(negedge clk);
        chk("to.rvalid_end", W'(rvalid_a), 0);

        // ack in the very cycle the timeout expires: ack wins
        req_m = 1'b1; addr_m = 32'h210;
        @(negedge clk);
        req_m = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("tie.req_s", W'(req_s_a), 5'b00100);
        chk("tie.no_rvalid", W'(rvalid_a), 0);
        ack_s = 5'b00100;
        rd_s  = {R{32'h13572468}};
        @(negedge clk);
        ack_s = '0;
        chk("tie.rvalid", W'(rvalid_a), 1);
        chk("tie.err", W'(err_a), 0);
        chk("tie.rd", rd_a, 32'h13572468);
        @(negedge clk);

        // overlapping regions: lowest index wins; other ports' acks ignored
        set_region(0, 32'h000, 32'h200);
        req_m = 1'b1; addr_m = 32'h150;
        @(negedge clk);
        req_m = 1'b0;
        chk("ov.req_s", W'(req_s_a), 5'b00001);
        chk("ov.addr_a", sl(addr_s_a, 0), 32'h150);
        chk("ov.addr_r", sl(addr_s_r, 0), 32'h150);
        ack_s = 5'b00010;
        rd_s  = {R{32'h0BADF00D}};
        @(negedge clk);
        chk("ov.ign_ack", W'(rvalid_a), 0);
        chk("ov.hold", W'(req_s_a), 5'b00001);
        ack_s = 5'b00001;
        @(negedge clk);
        ack_s = '0;
        chk("ov.rvalid", W'(rvalid_a), 1);
        chk("ov.rd", rd_a, 32'h0BADF00D);
        @(negedge clk);
        xfer("rd400", 1'b0, 32'h400, 32'h0, 5'b00000, 0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        set_region(0, 32'h000, 32'h100);

        // reset in the middle of a wait
        req_m = 1'b1; addr_m = 32'h104;
        @(negedge clk);
        req_m = 1'b0;
        chk("rw.req_s", W'(req_s_a), 5'b00010);
        #2 rst = 1'b1;
        #1;
        chk("rw.req_drop", W'(req_s_a), 0);
        chk("rw.ready_rst", W'(ready_a), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rw.no_rvalid", W'(rvalid_a), 0);
        end
        chk("rw.ready", W'(ready_a), 1);
        xfer("rw.fresh", 1'b0, 32'h020, 32'h0, 5'b00001, 0, 32'h600D600D,
             32'h600D600D, 1'b0, 32'h020, 32'h020);

        // final report
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
